// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port dmem arbiter, CPU priority with an aging counter bounding aux starvation.
// Define DMEM_ARB_PROTECT_EN to block aux writes below PROT_LIMIT.
module dmem_arbiter #(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 32,
    parameter int                MAX_WAIT   = 4,
    parameter logic [ADDR_W-1:0] PROT_LIMIT = 12'h100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_mem,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_stall,
    input  logic              aux_req,
    input  logic              aux_wren,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_data,
    output logic              aux_gnt,
    output logic              aux_valid,
    output logic [DATA_W-1:0] aux_q,
    output logic              aux_err,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut,
    output logic [15:0]       stall_cnt
);
    localparam int             WCW      = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    logic [WCW-1:0] wait_cnt_r;
    logic           resp_pend_r;
    logic           resp_err_r;
    logic [15:0]    stall_cnt_r;
    logic           force_s;
    logic           gnt_s;
    logic           stall_s;
    logic           blocked_s;

    // Grant decision; everything is held inactive while reset is asserted
    always_comb begin
        force_s = 1'b0;
        gnt_s   = 1'b0;
        stall_s = 1'b0;
        if (reset) begin
            force_s = 1'b0;
        end else begin
            force_s = aux_req & (wait_cnt_r == WAIT_MAX);
            gnt_s   = aux_req & (~cpu_mem | force_s);
            stall_s = cpu_mem & force_s;
        end
    end

`ifdef DMEM_ARB_PROTECT_EN
    assign blocked_s = gnt_s & aux_wren & (aux_addr < PROT_LIMIT);
`else
    logic [ADDR_W-1:0] prot_limit_unused;
    assign prot_limit_unused = PROT_LIMIT;
    assign blocked_s         = 1'b0;
`endif

    // RAM port mux: aux owns the port only in its grant cycle
    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = cpu_addr;
        ram_dataIn = cpu_data;
        if (reset) begin
            ram_wEn = 1'b0;
        end else if (gnt_s) begin
            ram_wEn    = aux_wren & ~blocked_s;
            ram_addr   = aux_addr;
            ram_dataIn = aux_data;
        end else begin
            ram_wEn = cpu_mem & cpu_wren;
        end
    end

    // Aging counter, completion flags and stall statistics
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_r  <= '0;
            resp_pend_r <= 1'b0;
            resp_err_r  <= 1'b0;
            stall_cnt_r <= 16'd0;
        end else begin
            if (gnt_s || !aux_req) begin
                wait_cnt_r <= '0;
            end else if (wait_cnt_r != WAIT_MAX) begin
                wait_cnt_r <= wait_cnt_r + WCW'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            resp_pend_r <= gnt_s;
            resp_err_r  <= gnt_s & blocked_s;
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign aux_gnt   = gnt_s;
    assign cpu_stall = stall_s;
    assign aux_valid = resp_pend_r;
    assign aux_err   = resp_err_r;
    assign aux_q     = ram_dataOut;
    assign cpu_q     = ram_dataOut;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed plan steps then random traffic, against a
// behavioural model of grants, RAM contents and aux completions.
module tb_dmem_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_mem = 1'b0;
    logic          cpu_wren = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic          aux_req = 1'b0;
    logic          aux_wren = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic [DW-1:0] aux_data = '0;
    logic [DW-1:0] cpu_q, aux_q, ram_dataIn;
    logic [DW-1:0] ram_dataOut = '0;
    logic          cpu_stall, aux_gnt, aux_valid, aux_err, ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [15:0]   stall_cnt;

    logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_mem(cpu_mem), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_q(cpu_q), .cpu_stall(cpu_stall),
        .aux_req(aux_req), .aux_wren(aux_wren), .aux_addr(aux_addr), .aux_data(aux_data),
        .aux_gnt(aux_gnt), .aux_valid(aux_valid), .aux_q(aux_q), .aux_err(aux_err),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
        .ram_dataOut(ram_dataOut), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // Synchronous RAM with one-cycle read latency
    always @(posedge clock) begin
        if (ram_wEn) ram[ram_addr] <= ram_dataIn;
        ram_dataOut <= ram[ram_addr];
    end

    // Reference model state
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
    int            age = 0;
    int            stalls = 0;
    bit            pend = 0, pend_err = 0, pend_rd = 0, cpu_rd_prev = 0, last_gnt = 0;
    logic [DW-1:0] pend_q = '0, cpu_rd_q = '0;
    int            errors = 0, checks = 0;
    bit            r_req = 0, r_wr = 0;
    logic [AW-1:0] r_addr = '0;
    logic [DW-1:0] r_data = '0;

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the negedge, check mid-cycle, advance the model
    task automatic cyc(input logic cm, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
        bit e_gnt, e_stall, e_blk, e_wen;
        cpu_mem = cm; cpu_wren = cw; cpu_addr = ca; cpu_data = cd;
        aux_req = ar; aux_wren = aw; aux_addr = aa; aux_data = ad;
        #1;
        e_gnt   = ar && (!cm || age == MW);
        e_stall = cm && ar && (age == MW);
`ifdef DMEM_ARB_PROTECT_EN
        e_blk = e_gnt && aw && (aa < 12'h100);
`else
        e_blk = 1'b0;
`endif
        e_wen = e_gnt ? (aw && !e_blk) : (cm && cw);
        chk1("aux_gnt", aux_gnt, e_gnt);
        chk1("cpu_stall", cpu_stall, e_stall);
        chk1("ram_wEn", ram_wEn, e_wen);
        if (e_wen) begin
            chkw("ram_addr", DW'(ram_addr), DW'(e_gnt ? aa : ca));
            chkw("ram_dataIn", ram_dataIn, e_gnt ? ad : cd);
        end
        chk1("aux_valid", aux_valid, pend);
        chk1("aux_err", aux_err, pend && pend_err);
        if (pend && pend_rd) begin
            chkw("aux_q", aux_q, pend_q);
            chkw("cpu_q_eq_aux_q", cpu_q, pend_q);
        end
        if (cpu_rd_prev) chkw("cpu_q", cpu_q, cpu_rd_q);
        chkw("stall_cnt", DW'(stall_cnt), DW'(stalls));
        cpu_rd_prev = cm && !cw && !e_stall;
        cpu_rd_q    = mdl_mem[ca];
        pend        = e_gnt;
        pend_err    = e_blk;
        pend_rd     = e_gnt && !aw;
        pend_q      = mdl_mem[aa];
        if (e_wen) begin
            if (e_gnt) mdl_mem[aa] = ad;
            else       mdl_mem[ca] = cd;
        end
        if (e_stall && stalls < 65535) stalls++;
        if (!ar || e_gnt) age = 0;
        else if (age < MW) age++;
        last_gnt = e_gnt;
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    // Hold reset for one rising edge while requests are active
    task automatic do_reset();
        reset = 1'b1;
        cpu_mem = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h3F0; cpu_data = 32'hBAD0BAD0;
        aux_req = 1'b1; aux_wren = 1'b1; aux_addr = 12'h3F1; aux_data = 32'hBAD1BAD1;
        #1;
        chk1("rst_aux_valid", aux_valid, 1'b0);
        chk1("rst_aux_err", aux_err, 1'b0);
        chk1("rst_aux_gnt", aux_gnt, 1'b0);
        chk1("rst_cpu_stall", cpu_stall, 1'b0);
        chk1("rst_ram_wEn", ram_wEn, 1'b0);
        chkw("rst_stall_cnt", DW'(stall_cnt), 32'd0);
        pend = 0; pend_err = 0; pend_rd = 0; cpu_rd_prev = 0; age = 0; stalls = 0;
        @(negedge clock);
        reset = 1'b0;
        cpu_mem = 1'b0; aux_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mdl_mem[i] = '0;
        do_reset();

        // CPU idle: aux read granted in the request cycle
        cyc(1'b1, 1'b1, 12'h200, 32'hDEADBEEF, 1'b0, 1'b0, 12'h000, 32'h0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h200, 32'h0);
        chk1("tp1_valid", aux_valid, 1'b1);
        chkw("tp1_aux_q", aux_q, 32'hDEADBEEF);
        idle();

        // Continuous CPU traffic: forced grant on the fifth request cycle
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
        chk1("tp2_valid", aux_valid, 1'b1);
        chkw("tp2_stall_cnt", DW'(stall_cnt), 32'd1);
        cyc(1'b1, 1'b0, 12'h011, 32'h0, 1'b1, 1'b0, 12'h021, 32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 12'h012, 32'h0, 1'b1, 1'b0, 12'h021, 32'h0);
        idle();

        // CPU store while aux is refused, then aux reads it back
        cyc(1'b1, 1'b1, 12'h300, 32'h1, 1'b1, 1'b0, 12'h300, 32'h0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h300, 32'h0);
        chkw("tp3_aux_q", aux_q, 32'h1);
        idle();

        // Aux writes on either side of the protection boundary
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h0FF, 32'h55);
`ifdef DMEM_ARB_PROTECT_EN
        chk1("tp4_err_0ff", aux_err, 1'b1);
`else
        chk1("tp4_err_0ff", aux_err, 1'b0);
`endif
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h100, 32'h55);
        chk1("tp4_err_100", aux_err, 1'b0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h0FF, 32'h0);
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h100, 32'h0);
        chkw("tp4_rd_100", aux_q, 32'h55);
        idle();

        // Reset in the cycle after a grant discards the response
        cyc(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h200, 32'h0);
        do_reset();
        cyc(1'b1, 1'b1, 12'h301, 32'h77, 1'b0, 1'b0, 12'h000, 32'h0);
        chk1("tp5_no_valid", aux_valid, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 12'h301, 32'h0, 1'b1, 1'b0, 12'h022, 32'h0);
        idle();

        // Abandoned aux request under load: no write, aging restarts from zero
        cyc(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b1, 12'h150, 32'hCAFE);
        cyc(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b1, 12'h150, 32'hCAFE);
        cyc(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b0, 12'h150, 32'h0);
        chkw("tp6_rd_150", aux_q, 32'h0);
        idle();

        // Random traffic around the protection boundary
        for (int i = 0; i < 600; i++) begin
            logic cm, cw;
            logic [AW-1:0] ca;
            if (!r_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    r_req  = 1;
                    r_wr   = ($urandom_range(0, 1) == 1);
                    r_addr = AW'($urandom_range(240, 272));
                    r_data = $urandom();
                end
            end else if ($urandom_range(0, 15) == 0) begin
                r_req = 0;
            end
            cm = ($urandom_range(0, 3) != 0);
            cw = ($urandom_range(0, 1) == 1);
            ca = AW'($urandom_range(240, 272));
            cyc(cm, cw, ca, $urandom(), r_req, r_wr, r_addr, r_data);
            if (last_gnt) r_req = 0;
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
